codec_cfg_sequencer: RTL
========================

Name: codec_cfg_sequencer

Overview:
- Controller that sequences the byte-level I2C engine to configure the audio codec.
- On `start`, it walks a configuration table of register writes. Each entry is one 3-byte I2C write: device address, register address, data.
- After init completes, it arbitrates runtime host write requests (volume, mute) onto the same engine.
- NACKed writes are retried a bounded number of times; exhausting retries flags an error.

Parameters:
- `C_CLK_DIVISOR`, 16'd2, SCL period in clk cycles; must match the engine.
- `C_NUM_REGS`, 8'd16, number of table entries (1..255).
- `C_MAX_RETRY`, 4'd3, retries per entry after the first attempt.
- `C_STOP_WAIT`, 2*C_CLK_DIVISOR+2, cycles waited after dropping `eng_go` before the next transaction.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  one-cycle pulse; begin init sequence
- `busy`  out  1  sequencer not idle
- `init_done`  out  1  level; table completed with all entries ACKed
- `init_err`  out  1  level; an entry exhausted retries
- `err_index`  out  8  table index of the failing entry
- `tbl_addr`  out  8  configuration ROM address
- `tbl_data`  in  24  {dev_addr, reg_addr, data}; valid 1 cycle after `tbl_addr`
- `req_valid`  in  1  host write request
- `req_data`  in  24  host write {dev_addr, reg_addr, data}
- `req_ready`  out  1  request accepted this cycle
- `req_nack`  out  1  one-cycle pulse; host write failed after retries
- `eng_go`  out  1  engine go
- `eng_rnw`  out  1  engine read-not-write; constant 0
- `eng_wdata`  out  8  byte to engine
- `eng_done`  in  1  engine done; high during an ACK bit phase
- `eng_ack`  in  1  one-cycle pulse; slave ACKed the byte

Behaviour:
- **Reset (async, rst_n=0):** all outputs 0, `tbl_addr`=0, state S_IDLE. Reset mid-transaction drops `eng_go` immediately.
- **States:** S_IDLE, S_FETCH, S_FETCH_WAIT, S_XFER, S_STOP_WAIT, S_CHECK, S_HOST_IDLE, S_ERROR.
- **S_IDLE:**
  - `start` → clear `init_done`/`init_err`, index=0, retry=0, → S_FETCH.
  - `start` while not in S_IDLE/S_HOST_IDLE/S_ERROR is ignored.
- **S_FETCH:** drive `tbl_addr`=index → S_FETCH_WAIT (1 cycle). Latch `tbl_data` into the 24-bit txn register → S_XFER.
- **S_XFER:**
  - First cycle: `eng_wdata`=txn[23:16], `eng_go`=1, byte_idx=0, ack_cnt=0.
  - On each rising edge of `eng_done` (done & ~done_q): byte_idx++.
  - When byte_idx goes 0→1, `eng_wdata`=txn[15:8]; 1→2, `eng_wdata`=txn[7:0].
  - On the 3rd done rise, `eng_go`=0 the following cycle; this is still inside the ACK phase, so the engine issues STOP. → S_STOP_WAIT.
- **ACK counting:** `eng_ack` pulses increment a saturating 2-bit ack_cnt throughout S_XFER and S_STOP_WAIT. The pulse lands after the ACK phase, so the 3rd pulse arrives in S_STOP_WAIT.
- **S_STOP_WAIT:** count `C_STOP_WAIT` cycles → S_CHECK.
- **S_CHECK:**
  - If ack_cnt==3: success, retry=0.
    - Init: index++. If index==`C_NUM_REGS`, set `init_done` → S_HOST_IDLE; else → S_FETCH.
    - Host: → S_HOST_IDLE.
  - Else if retry<`C_MAX_RETRY`: retry++, reissue the same txn → S_XFER (no refetch).
  - Else:
    - Init: `init_err`=1, `err_index`=index → S_ERROR.
    - Host: `req_nack` pulse → S_HOST_IDLE.
- **S_HOST_IDLE:**
  - If `req_valid`: `req_ready`=1 for one cycle, latch `req_data`, retry=0 → S_XFER.
  - `start` has priority over `req_valid` in the same cycle: re-init, no `req_ready`.
- **S_ERROR:** holds `init_err`. `start` → re-run from index 0. Host requests are not accepted.
- **`req_ready`:** 0 in every state other than S_HOST_IDLE.
- **`busy`:** 1 in all states except S_IDLE, S_HOST_IDLE and S_ERROR.
- **`eng_wdata`:** held stable except at the defined update points.
- **Widths:** index 8-bit, retry 4-bit. `C_NUM_REGS`=1 completes after a single entry.

Test Plan:
- **Clean init:** `C_NUM_REGS`=3, table {0x34,0x1E,0x00},{0x34,0x0C,0x10},{0x34,0x12,0x01}, slave ACKs all → 3 transactions, `eng_wdata` sequence 34,1E,00,34,0C,10,34,12,01; then `init_done`=1, `busy`=0, `init_err`=0.
- **Single retry:** entry 1 NACKs its second byte once → entry 1 issued twice, exactly 4 transactions total, `init_done`=1.
- **Retry exhaustion:** entry 2 always NACKs, `C_MAX_RETRY`=3 → 4 attempts on entry 2, `init_err`=1, `err_index`=2, `init_done`=0, and `req_valid` is not acked.
- **Host write:** after init, `req_valid` with `req_data`=0x340A55 → `req_ready` pulse within 1 cycle, bytes 34,0A,55, no `req_nack`. With the slave NACKing → 4 attempts, then a `req_nack` pulse.
- **Priority and ignore:** `start` and `req_valid` asserted together in S_HOST_IDLE → init restarts at index 0, `req_ready` stays 0. `start` pulsed mid-transaction → ignored, sequence unaffected.
- **Async reset:** `rst_n` low during byte 2 of entry 1 → `eng_go`=0 and `busy`=0 immediately. After release, `start` re-runs from `tbl_addr`=0.

Source files
------------

// File: rtl/codec_cfg_sequencer.sv
// Codec configuration sequencer: replays a table of 3-byte I2C register writes
// through the byte engine, then serves host writes, retrying NACKed transfers.
module codec_cfg_sequencer #(
   parameter logic [15:0] C_CLK_DIVISOR = 16'd2,
   parameter logic [7:0]  C_NUM_REGS    = 8'd16,
   parameter logic [3:0]  C_MAX_RETRY   = 4'd3,
   parameter logic [15:0] C_STOP_WAIT   = 16'd2 * C_CLK_DIVISOR + 16'd2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        busy,
   output logic        init_done,
   output logic        init_err,
   output logic [7:0]  err_index,
   output logic [7:0]  tbl_addr,
   input  logic [23:0] tbl_data,
   input  logic        req_valid,
   input  logic [23:0] req_data,
   output logic        req_ready,
   output logic        req_nack,
   output logic        eng_go,
   output logic        eng_rnw,
   output logic [7:0]  eng_wdata,
   input  logic        eng_done,
   input  logic        eng_ack
);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_FETCH      = 3'd1,
      S_FETCH_WAIT = 3'd2,
      S_XFER       = 3'd3,
      S_STOP_WAIT  = 3'd4,
      S_CHECK      = 3'd5,
      S_HOST_IDLE  = 3'd6,
      S_ERROR      = 3'd7
   } state_t;

   state_t      state_r, state_s;
   logic [7:0]  index_r, index_s;
   logic [3:0]  retry_r, retry_s;
   logic [23:0] txn_r, txn_s;
   logic [1:0]  byte_idx_r, byte_idx_s;
   logic [1:0]  ack_cnt_r, ack_cnt_s;
   logic [15:0] wait_cnt_r, wait_cnt_s;
   logic        host_r, host_s;
   logic        done_q_r;
   logic        eng_go_r, eng_go_s;
   logic [7:0]  eng_wdata_r, eng_wdata_s;
   logic [7:0]  tbl_addr_r, tbl_addr_s;
   logic        init_done_r, init_done_s;
   logic        init_err_r, init_err_s;
   logic [7:0]  err_index_r, err_index_s;
   logic        req_nack_r, req_nack_s;
   logic        busy_r, busy_s;
   logic        launch_s;
   logic        done_rise_s;
   logic        restart_s;
   logic        req_ready_s;

   assign done_rise_s = eng_done & ~done_q_r;
   assign restart_s   = start & ((state_r == S_IDLE) | (state_r == S_HOST_IDLE) | (state_r == S_ERROR));
   // Acceptance is a decode of the current cycle so the host sees a true same-cycle handshake.
   assign req_ready_s = (state_r == S_HOST_IDLE) & req_valid & ~start;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= S_IDLE;
         index_r     <= 8'd0;
         retry_r     <= 4'd0;
         txn_r       <= 24'd0;
         byte_idx_r  <= 2'd0;
         ack_cnt_r   <= 2'd0;
         wait_cnt_r  <= 16'd0;
         host_r      <= 1'b0;
         done_q_r    <= 1'b0;
         eng_go_r    <= 1'b0;
         eng_wdata_r <= 8'd0;
         tbl_addr_r  <= 8'd0;
         init_done_r <= 1'b0;
         init_err_r  <= 1'b0;
         err_index_r <= 8'd0;
         req_nack_r  <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         index_r     <= index_s;
         retry_r     <= retry_s;
         txn_r       <= txn_s;
         byte_idx_r  <= byte_idx_s;
         ack_cnt_r   <= ack_cnt_s;
         wait_cnt_r  <= wait_cnt_s;
         host_r      <= host_s;
         done_q_r    <= eng_done;
         eng_go_r    <= eng_go_s;
         eng_wdata_r <= eng_wdata_s;
         tbl_addr_r  <= tbl_addr_s;
         init_done_r <= init_done_s;
         init_err_r  <= init_err_s;
         err_index_r <= err_index_s;
         req_nack_r  <= req_nack_s;
         busy_r      <= busy_s;
      end
   end

   // Next-state, transaction sequencing and retry policy
   always_comb begin
      state_s     = state_r;
      index_s     = index_r;
      retry_s     = retry_r;
      txn_s       = txn_r;
      byte_idx_s  = byte_idx_r;
      wait_cnt_s  = wait_cnt_r;
      host_s      = host_r;
      eng_go_s    = eng_go_r;
      eng_wdata_s = eng_wdata_r;
      tbl_addr_s  = tbl_addr_r;
      init_done_s = init_done_r;
      init_err_s  = init_err_r;
      err_index_s = err_index_r;
      req_nack_s  = 1'b0;
      launch_s    = 1'b0;

      // The last ACK pulse trails the ACK phase, so counting continues through the stop wait.
      if (eng_ack && ((state_r == S_XFER) || (state_r == S_STOP_WAIT)) && (ack_cnt_r != 2'd3)) begin
         ack_cnt_s = ack_cnt_r + 2'd1;
      end else begin
         ack_cnt_s = ack_cnt_r;
      end

      case (state_r)
         S_IDLE: begin
            state_s = S_IDLE;
         end
         S_FETCH: begin
            state_s = S_FETCH_WAIT;
         end
         S_FETCH_WAIT: begin
            txn_s    = tbl_data;
            launch_s = 1'b1;
            state_s  = S_XFER;
         end
         S_XFER: begin
            if (done_rise_s) begin
               byte_idx_s = byte_idx_r + 2'd1;
               case (byte_idx_r)
                  2'd0: eng_wdata_s = txn_r[15:8];
                  2'd1: eng_wdata_s = txn_r[7:0];
                  default: begin
                     // Dropping go inside the ACK phase makes the engine issue STOP.
                     eng_go_s   = 1'b0;
                     wait_cnt_s = 16'd0;
                     state_s    = S_STOP_WAIT;
                  end
               endcase
            end else begin
               state_s = S_XFER;
            end
         end
         S_STOP_WAIT: begin
            if ((wait_cnt_r + 16'd1) >= C_STOP_WAIT) begin
               state_s = S_CHECK;
            end else begin
               wait_cnt_s = wait_cnt_r + 16'd1;
            end
         end
         S_CHECK: begin
            if (ack_cnt_r == 2'd3) begin
               retry_s = 4'd0;
               if (host_r) begin
                  state_s = S_HOST_IDLE;
               end else begin
                  index_s = index_r + 8'd1;
                  if ((index_r + 8'd1) == C_NUM_REGS) begin
                     init_done_s = 1'b1;
                     state_s     = S_HOST_IDLE;
                  end else begin
                     tbl_addr_s = index_r + 8'd1;
                     state_s    = S_FETCH;
                  end
               end
            end else if (retry_r < C_MAX_RETRY) begin
               retry_s  = retry_r + 4'd1;
               launch_s = 1'b1;
               state_s  = S_XFER;
            end else if (host_r) begin
               req_nack_s = 1'b1;
               state_s    = S_HOST_IDLE;
            end else begin
               init_err_s  = 1'b1;
               err_index_s = index_r;
               state_s     = S_ERROR;
            end
         end
         S_HOST_IDLE: begin
            if (req_ready_s) begin
               txn_s    = req_data;
               retry_s  = 4'd0;
               host_s   = 1'b1;
               launch_s = 1'b1;
               state_s  = S_XFER;
            end else begin
               state_s = S_HOST_IDLE;
            end
         end
         S_ERROR: begin
            state_s = S_ERROR;
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase

      if (restart_s) begin
         init_done_s = 1'b0;
         init_err_s  = 1'b0;
         index_s     = 8'd0;
         retry_s     = 4'd0;
         host_s      = 1'b0;
         tbl_addr_s  = 8'd0;
         state_s     = S_FETCH;
      end else begin
         host_s = host_s;
      end

      if (launch_s) begin
         eng_go_s    = 1'b1;
         eng_wdata_s = txn_s[23:16];
         byte_idx_s  = 2'd0;
         ack_cnt_s   = 2'd0;
      end else begin
         byte_idx_s = byte_idx_s;
      end

      busy_s = ~((state_s == S_IDLE) | (state_s == S_HOST_IDLE) | (state_s == S_ERROR));
   end

   assign busy      = busy_r;
   assign init_done = init_done_r;
   assign init_err  = init_err_r;
   assign err_index = err_index_r;
   assign tbl_addr  = tbl_addr_r;
   assign req_ready = req_ready_s;
   assign req_nack  = req_nack_r;
   assign eng_go    = eng_go_r;
   assign eng_rnw   = 1'b0;
   assign eng_wdata = eng_wdata_r;

endmodule
